// File: rtl/updown_counter_bounded.sv
// updown_counter_bounded: bounded up/down counter with programmable step, wrap/saturate,
// registered terminal-count pulse and sticky overflow/underflow flags.
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   reset_n_i    synchronous active-low reset
//   en_i         count/load enable
//   load_i       synchronous load of din_i (qualified by en_i)
//   mode_i       0 = count up, 1 = count down
//   sat_i        0 = wrap at bounds, 1 = saturate at bounds
//   step_i       increment/decrement amount
//   min_val_i    lower bound (unsigned)
//   max_val_i    upper bound (unsigned)
//   din_i        load data
//   clr_flags_i  synchronous clear of the sticky flags
//   q_o          registered counter value
//   tc_o         registered one-cycle terminal-count pulse
//   ovf_o        sticky overflow flag
//   udf_o        sticky underflow flag
//   at_max_o     combinational q_o == max_val_i
//   at_min_o     combinational q_o == min_val_i
//   cfg_err_o    combinational min_val_i > max_val_i
module updown_counter_bounded #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             mode_i,
  input  logic             sat_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic [WIDTH-1:0] min_val_i,
  input  logic [WIDTH-1:0] max_val_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             clr_flags_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             ovf_o,
  output logic             udf_o,
  output logic             at_max_o,
  output logic             at_min_o,
  output logic             cfg_err_o
);
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d, ovf_q, ovf_d, udf_q, udf_d;
  logic [WIDTH:0]   up_sum, dn_lim;
  logic             do_load, do_count, up_evt, dn_evt;
  // One extra bit keeps q+step and min+step from wrapping before the compare.
  assign up_sum   = {1'b0, q_q} + {1'b0, step_i};
  assign dn_lim   = {1'b0, min_val_i} + {1'b0, step_i};
  assign up_evt   = up_sum > {1'b0, max_val_i};
  assign dn_evt   = {1'b0, q_q} < dn_lim;
  assign do_load  = en_i & load_i;
  // A zero step or inverted bounds freezes counting entirely, so no event can fire.
  assign do_count = en_i & ~load_i & ~cfg_err_o & (step_i != '0);
  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q & ~clr_flags_i;
    udf_d = udf_q & ~clr_flags_i;
    if (do_load) begin
      q_d = din_i;
    end else if (do_count && !mode_i) begin
      q_d   = up_evt ? (sat_i ? max_val_i : min_val_i) : up_sum[WIDTH-1:0];
      tc_d  = up_evt;
      ovf_d = ovf_d | up_evt;
    end else if (do_count) begin
      q_d   = dn_evt ? (sat_i ? min_val_i : max_val_i) : q_q - step_i;
      tc_d  = dn_evt;
      udf_d = udf_d | dn_evt;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      q_q   <= RESET_VAL;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
  assign q_o       = q_q;
  assign tc_o      = tc_q;
  assign ovf_o     = ovf_q;
  assign udf_o     = udf_q;
  assign at_max_o  = q_q == max_val_i;
  assign at_min_o  = q_q == min_val_i;
  assign cfg_err_o = min_val_i > max_val_i;
endmodule

// File: doc/updown_counter_bounded.md
Name: updown_counter_bounded

Overview:
- Parametrised successor to the 4-bit up/down counter.
- Generic width, runtime-programmable step and [min,max] bounds, and selectable wrap or saturate.
- Adds a registered terminal-count pulse and sticky overflow/underflow flags.
- Used as a general timer/event/pointer counter inside datapath and control blocks.

Parameters:
- WIDTH, 8, counter and bound width in bits (>= 2).
- RESET_VAL, 0, value of q after reset; must fit in WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- en  in  1  count/load enable.
- load  in  1  synchronous load of din; effective only when en=1.
- mode  in  1  0 = count up, 1 = count down.
- sat  in  1  0 = wrap at bounds, 1 = saturate at bounds.
- step  in  WIDTH  increment/decrement amount.
- min_val  in  WIDTH  lower bound, unsigned.
- max_val  in  WIDTH  upper bound, unsigned.
- din  in  WIDTH  load data.
- clr_flags  in  1  synchronous clear of the sticky flags.
- q  out  WIDTH  counter value; registered.
- tc  out  1  one-cycle pulse; registered.
- ovf  out  1  sticky overflow flag.
- udf  out  1  sticky underflow flag.
- at_max  out  1  combinational (q == max_val).
- at_min  out  1  combinational (q == min_val).
- cfg_err  out  1  combinational (min_val > max_val).

Behaviour:
- Reset (reset_n=0 at a rising edge): q=RESET_VAL, tc=0, ovf=0, udf=0. Reset overrides all other inputs, including mid-count and mid-load. at_min, at_max and cfg_err follow q and the bounds immediately.
- Priority per edge: reset > (en & load) > (en & count) > hold.
- en=0: q holds, tc=0, and no flag is set. clr_flags still acts.
- Load (en=1, load=1): q <= din unconditionally, even when din lies outside [min_val,max_val]. No tc, no flag set.
- Count (en=1, load=0): all arithmetic is unsigned and evaluated at WIDTH+1 bits, so no intermediate wrap occurs.
- Up (mode=0):
  - If q+step <= max_val: q <= q+step.
  - Otherwise this is an overflow event: q <= (sat ? max_val : min_val), tc <= 1, ovf <= 1.
- Down (mode=1):
  - If q >= min_val+step: q <= q-step.
  - Otherwise this is an underflow event: q <= (sat ? min_val : max_val), tc <= 1, udf <= 1.
- Wrap lands exactly on the opposite bound. The overshoot remainder is discarded.
- Saturate mode: every further step at a bound re-raises the event, so tc pulses every enabled cycle while pinned at the bound.
- step=0: q holds, no event.
- cfg_err=1 during a count: q holds, tc=0, no flags set. Load still works.
- Out-of-range q after a load: the same rules apply.
  - q>max_val counting up overflows on the first step.
  - q<min_val counting down underflows on the first step.
- tc is high exactly in the cycle after the edge that produced the event; otherwise 0.
- Sticky flags:
  - clr_flags=1 clears ovf and udf on the edge.
  - If an event occurs on the same edge, the set wins for that flag.
- Latency: q, tc and the flags update one edge after inputs are sampled. at_* and cfg_err have zero latency.
- When min_val=max_val and step>0, every count is an event. q settles at the bound.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=5. Drive reset_n=0 for one edge during counting -> q=5, tc=0, ovf=0, udf=0 on the next edge. Release reset_n and hold en=0 -> q stays 5.
- Up wrap: min=10, max=20, step=3, sat=0. Load 18, then count up -> q=10, tc=1 for one cycle, ovf=1. Next count -> q=13, tc=0, ovf still 1.
- Down saturate: min=10, max=20, step=4, sat=1. Load 12, then count down 3 cycles -> q=10,10,10 with tc=1 on each; udf=1 and at_min=1.
- Full-range arithmetic: min=0, max=255, step=1. Load 255 and count up with sat=0 -> q=0 with ovf. Load 0 and count down -> q=255 with udf.
- Flags and priority:
  - clr_flags together with an overflow event on the same edge -> ovf stays 1.
  - clr_flags alone -> ovf=0.
  - load=1 and en=1 at a bound -> q=din, no tc.
  - load=1 and en=0 -> no change.
- Config error / step 0: min=30, max=20 -> cfg_err=1, counting leaves q unchanged, and a load of 7 gives q=7. Valid bounds with step=0 -> q unchanged, tc=0.
